instruction_sequencer: RTL and testbench

- Producer side of the 10-bit instruction interface consumed by control_unit.
- Holds a small program memory, a program counter and a registered instruction output.
- Issues one instruction per cycle to the decoder and honours the decoder's jump request (load/set_value).
- Inserts a pipeline bubble on a taken jump, supports stall, and halts on opcode 1111.

---
 rtl/instruction_sequencer.sv | 112 +++++++++++
 tb/tb_instruction_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Program memory, program counter and registered instruction issue for control_unit.
// One instruction per cycle; a taken jump costs one bubble; opcode 1111 halts.
module instruction_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 10,
  parameter int MEM_DEPTH   = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   prog_we,
  input  logic [PC_WIDTH-1:0]    prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   load,
  input  logic [PC_WIDTH-1:0]    set_value,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   running,
  output logic                   halted
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic                   running_q, halted_q;
  logic [INSTR_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic                   mem_we_s;
  logic                   is_halt_s;

  assign mem_we_s  = prog_we && (state_q != ST_RUN);
  assign is_halt_s = valid_q && (instr_q[INSTR_WIDTH-1 -: 4] == 4'hF);

  // Program memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // Next-state logic: stall beats halt, halt beats jump, jump beats fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        valid_d = 1'b0;
        if (start && !prog_we) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (stall) begin
          state_d = ST_RUN;
        end else if (is_halt_s) begin
          state_d = ST_HALT;
          valid_d = 1'b0;
        end else if (valid_q && load) begin
          pc_d    = set_value;
          valid_d = 1'b0;
        end else begin
          instr_d = mem_q[pc_q];
          valid_d = 1'b1;
          pc_d    = pc_q + PC_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      running_q <= (state_d == ST_RUN);
      halted_q  <= (state_d == ST_HALT);
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign running     = running_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: scoreboard of issued instructions
// plus cycle-exact checks of pc / instr_valid / running / halted.
module tb_instruction_sequencer;

  logic       clk;
  logic       rst_n;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [9:0] prog_data;
  logic       start;
  logic       stall;
  logic       load;
  logic [7:0] set_value;
  logic [9:0] instruction;
  logic       instr_valid;
  logic [7:0] pc;
  logic       running;
  logic       halted;

  int         checks;
  int         failures;
  logic [9:0] exp_q [$];
  logic [9:0] tb_mem [256];

  instruction_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .start       (start),
    .stall       (stall),
    .load        (load),
    .set_value   (set_value),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .running     (running),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; pops the scoreboard whenever a fresh (non-stalled) instruction issues.
  task automatic tick();
    logic       stalled;
    logic [9:0] e;
    stalled = stall;
    @(posedge clk);
    #1;
    if (instr_valid === 1'b1 && !stalled) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 32'(instruction), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_instr", 32'(instruction), 32'(e));
      end
    end
  endtask

  task automatic prog(input logic [7:0] a, input logic [9:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tb_mem[a] = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic push(input logic [7:0] a);
    exp_q.push_back(tb_mem[a]);
  endtask

  task automatic chk_state(input string tag, input logic [7:0] epc, input logic ev,
                           input logic er, input logic eh);
    chk({tag, "_pc"}, 32'(pc), 32'(epc));
    chk({tag, "_valid"}, 32'(instr_valid), 32'(ev));
    chk({tag, "_running"}, 32'(running), 32'(er));
    chk({tag, "_halted"}, 32'(halted), 32'(eh));
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = 8'd0; prog_data = 10'd0;
    start = 1'b0; stall = 1'b0; load = 1'b0; set_value = 8'd0;
    repeat (3) tick();
    chk_state("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    chk("reset_instr", 32'(instruction), 32'd0);
    rst_n = 1'b1;

    // Straight-line program ending in a halt word
    prog(8'd0, 10'b0000000101);
    prog(8'd1, 10'b0001001101);
    prog(8'd2, 10'b0010101011);
    prog(8'd3, 10'b1111111111);
    chk_state("idle", 8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push(8'(i));
    start = 1'b1; tick(); start = 1'b0;
    chk_state("t1_start", 8'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_state("t1_run", 8'(i), 1'b1, 1'b1, 1'b0);
    end
    tick();
    chk_state("t1_halt", 8'd4, 1'b0, 1'b0, 1'b1);
    chk("t1_halt_instr", 32'(instruction), 32'h3FF);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Program in HALT, then a write coinciding with start must not start
    prog(8'd7,  10'b0001110000);
    prog(8'd8,  10'b0001110001);
    prog(8'd9,  10'b0001110010);
    prog(8'd10, 10'b0001110011);
    prog(8'd11, 10'b1111000000);
    start = 1'b1;
    prog(8'd1, 10'b1001000111);
    start = 1'b0;
    chk_state("t6_we_start", 8'd4, 1'b0, 1'b0, 1'b1);
    push(8'd0); push(8'd1); push(8'd7); push(8'd8);
    push(8'd9); push(8'd10); push(8'd11);
    start = 1'b1; tick(); start = 1'b0;
    chk_state("t6_restart", 8'd0, 1'b0, 1'b1, 1'b0);

    // Jump from mem[1] to 7; mem[2] must never issue
    tick();
    chk_state("t2_f0", 8'd1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_state("t2_f1", 8'd2, 1'b1, 1'b1, 1'b0);
    load = 1'b1; set_value = 8'h07;
    tick();
    chk_state("t2_bubble", 8'h07, 1'b0, 1'b1, 1'b0);
    chk("t2_bubble_instr", 32'(instruction), 32'(tb_mem[1]));
    set_value = 8'h20;
    tick();
    chk_state("t2_target", 8'h08, 1'b1, 1'b1, 1'b0);

    // Stall three cycles with a load pending
    stall = 1'b1; load = 1'b1; set_value = 8'h30;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state("t3_stall", 8'h08, 1'b1, 1'b1, 1'b0);
      chk("t3_stall_instr", 32'(instruction), 32'(tb_mem[7]));
    end
    stall = 1'b0; load = 1'b0;
    for (int i = 9; i <= 12; i++) begin
      tick();
      chk_state("t3_resume", 8'(i), 1'b1, 1'b1, 1'b0);
    end
    tick();
    chk_state("t3_halt", 8'd12, 1'b0, 1'b0, 1'b1);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Jump to 0xFF and wrap to 0
    prog(8'hFF, 10'b0000111100);
    push(8'd0); push(8'hFF); push(8'd0); push(8'd1);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk_state("t4_f0", 8'd1, 1'b1, 1'b1, 1'b0);
    load = 1'b1; set_value = 8'hFF;
    tick();
    load = 1'b0;
    chk_state("t4_bubble", 8'hFF, 1'b0, 1'b1, 1'b0);
    tick();
    chk_state("t4_ff", 8'h00, 1'b1, 1'b1, 1'b0);
    tick();
    chk_state("t4_wrap", 8'h01, 1'b1, 1'b1, 1'b0);

    // Write attempt in RUN, then async reset between edges
    prog_we = 1'b1; prog_addr = 8'd2; prog_data = 10'd0;
    tick();
    prog_we = 1'b0;
    chk_state("t5_run", 8'd2, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_state("t5_async", 8'd0, 1'b0, 1'b0, 1'b0);
    chk("t5_async_instr", 32'(instruction), 32'd0);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(i));
    start = 1'b1; tick(); start = 1'b0;
    chk_state("t5_restart", 8'd0, 1'b0, 1'b1, 1'b0);
    repeat (4) tick();
    tick();
    chk_state("t5_halt", 8'd4, 1'b0, 1'b0, 1'b1);
    chk("t5_sb_empty_end", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
